// File: rtl/rv_pkg.sv
// rv_pkg: shared M-extension encodings, muldiv FSM states and operand-sign helpers.
package rv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

    function automatic logic signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// rv_div_step: one restoring-division step; shifts a dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module rv_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] sh;
    logic [W:0] diff;

    // rem_i < div_i holds, so a non-negative difference always fits in W bits
    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {1'b0, div_i};
    assign q_o   = !diff[W];
    assign rem_o = q_o ? diff[W-1:0] : sh[W-1:0];

endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// Define RV_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier; divide stays iterative.
module rv_muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [2:0]       fun3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d, op_in;
    logic [XLEN-1:0]   dvs_q, dvs_d, result_q, result_d;
    logic [2*XLEN-1:0] prod_q, prod_d, step, fast_prod;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              nq_q, nq_d, nr_q, nr_d;
    logic [XLEN-1:0]   mag_a, mag_b, rem_n, spec_res;
    logic [XLEN:0]     sum;
    logic              a_neg, b_neg, q_bit, div0, ovf, fast_mul;

    function automatic logic [XLEN-1:0] fix(input muldiv_op_e op, input logic [2*XLEN-1:0] p,
                                            input logic nq, input logic nr);
        logic [2*XLEN-1:0] pm;
        logic [XLEN-1:0]   q, r;
        pm = nq ? -p : p;
        q  = nq ? -p[XLEN-1:0] : p[XLEN-1:0];
        r  = nr ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
        return op == OP_MUL ? pm[XLEN-1:0] : !op[2] ? pm[2*XLEN-1:XLEN] : op[1] ? r : q;
    endfunction

    assign op_in = muldiv_op_e'(fun3);
    assign a_neg = signed_a(op_in) && op_a[XLEN-1];
    assign b_neg = signed_b(op_in) && op_b[XLEN-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    assign div0     = fun3[2] && op_b == '0;
    assign ovf      = (op_in == OP_DIV || op_in == OP_REM) && &op_b &&
                      op_a == {1'b1, {(XLEN-1){1'b0}}};
    assign spec_res = div0 ? (fun3[1] ? op_a : '1) : (fun3[1] ? '0 : op_a);

`ifdef RV_MULDIV_FAST_MUL_EN
    assign fast_mul  = !fun3[2];
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
    assign fast_mul  = 1'b0;
    assign fast_prod = '0;
`endif

    rv_div_step #(.W(XLEN)) u_div_step (
        .rem_i (prod_q[2*XLEN-1:XLEN]),
        .bit_i (prod_q[XLEN-1]),
        .div_i (dvs_q),
        .rem_o (rem_n),
        .q_o   (q_bit)
    );

    // prod_q is {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, dvs_q} : '0);
    assign step = op_q[2] ? {rem_n, prod_q[XLEN-2:0], q_bit} : {sum, prod_q[XLEN-1:1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dvs_d    = dvs_q;
        prod_d   = prod_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        nq_d     = nq_q;
        nr_d     = nr_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE && in_valid) begin
            op_d     = op_in;
            tag_d    = in_tag;
            cnt_d    = '0;
            nq_d     = a_neg ^ b_neg;
            nr_d     = a_neg;
            dvs_d    = fun3[2] ? mag_b : mag_a;
            prod_d   = {{XLEN{1'b0}}, fun3[2] ? mag_a : mag_b};
            result_d = div0 || ovf ? spec_res : fix(op_in, fast_prod, a_neg ^ b_neg, a_neg);
            state_d  = div0 || ovf || fast_mul ? DONE : CALC;
        end else if (state_q == CALC) begin
            prod_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
                result_d = fix(op_q, step, nq_q, nr_q);
                state_d  = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            dvs_q    <= '0;
            prod_q   <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            nq_q     <= 1'b0;
            nr_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dvs_q    <= dvs_d;
            prod_q   <= prod_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            nq_q     <= nq_d;
            nr_q     <= nr_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign busy       = !in_ready;
    assign out_valid  = state_q == DONE;
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed-vector bench for rv_muldiv_unit (XLEN=32) with hand-computed results.
module tb_rv_muldiv_unit;

`ifdef RV_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [2:0]  fun3 = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .fun3       (fun3),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op from #1 after an edge and return the cycle (accept edge = 0) on which out_valid is seen
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output int n);
        fun3 = f; op_a = a; op_b = b; in_tag = tg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp,
                       input int lat);
        int n;
        out_ready = 1'b1;
        issue(f, a, b, tg, n);
        chk({name, " valid"}, 64'(out_valid), 64'd1);
        chk({name, " result"}, 64'(out_result), 64'(exp));
        chk({name, " tag"}, 64'(out_tag), 64'(tg));
        chk({name, " latency"}, 64'(n), 64'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int  n;
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst out_result", 64'(out_result), 64'd0);
        chk("rst out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);

        run("mul 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, MUL_LAT);
        run("mul big*16",    3'b000, 32'h12345678, 32'h10,       5'd3,  32'h23456780, MUL_LAT);
        run("mulhu -1*-1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, MUL_LAT);
        run("mulh -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, MUL_LAT);
        run("mulhsu -1*max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, MUL_LAT);
        run("div -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, DIV_LAT);
        run("rem -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, DIV_LAT);
        run("div 7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFD, DIV_LAT);
        run("rem 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 5'd8,  32'h00000001, DIV_LAT);
        run("divu 100/7",    3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       DIV_LAT);
        run("remu 100/7",    3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        DIV_LAT);
        run("div 5/0",       3'b100, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
        run("rem 5/0",       3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        1);
        run("divu 5/0",      3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        run("div ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run("rem ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1);

        // backpressure: result and tag held while the consumer stalls
        out_ready = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 5'd20, n);
        chk("bp valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold result", 64'(out_result), 64'd15);
            chk("bp hold tag", 64'(out_tag), 64'd20);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp valid held", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid", 64'(out_valid), 64'd0);
        chk("bp release in_ready", 64'(in_ready), 64'd1);

        // flush at CALC step 10
        fun3 = 3'b101; op_a = 32'd100; op_b = 32'd7; in_tag = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush in_ready", 64'(in_ready), 64'd1);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("flush no result", 64'(seen), 64'd0);

        // flush together with in_valid in IDLE must not accept
        fun3 = 3'b000; op_a = 32'd2; op_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush blocks accept", 64'(busy), 64'd0);
        run("after flush remu", 3'b111, 32'd100, 32'd7, 5'd22, 32'd2, DIV_LAT);

        // asynchronous reset mid-CALC
        fun3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; in_tag = 5'd23; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre-reset busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst result", 64'(out_result), 64'd0);
        chk("async rst tag", 64'(out_tag), 64'd0);
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("after reset divu", 3'b101, 32'd1000, 32'd3, 5'd24, 32'd333, DIV_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit that sits beside the single-cycle ALU in the EX stage.
- Accepts one operation at a time over a valid/ready handshake and computes it over multiple cycles.
- Returns the result plus the destination tag over a second valid/ready handshake, so the pipeline stalls only while dependent.
- Generalises the ALU in width (XLEN), adds M-extension ops and flush support.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- TAG_W, 5, width of the pass-through destination-register tag.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- fun3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_tag  in  TAG_W  destination tag, returned unchanged.
- flush  in  1  kill the in-flight op (branch mispredict/trap).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  computed result.
- out_tag  out  TAG_W  tag of the op that produced out_result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_result=0, out_tag=0, busy=0, in_ready=1 once out of reset; counter=0.
- FSM states:
  - IDLE: accept when in_valid && in_ready && !flush. Latch the operands, fun3 and tag. Go to CALC, or to DONE for special cases.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per cycle, with a counter from 0 to XLEN-1. After step XLEN-1, fix signs and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Latency: the accept edge is cycle 0; out_valid rises on cycle XLEN+1. Special cases: out_valid on cycle 1.
- Signed handling: the core is unsigned only.
  - Operands are converted to magnitudes per op: MULH both signed; MULHSU only op_a signed; DIV/REM both signed.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Result select:
  - MUL: low XLEN bits of the 2*XLEN product.
  - MULH*: high XLEN bits.
  - DIV*: quotient. REM*: remainder.
- Special cases (bypass CALC):
  - Divide by zero: DIV/DIVU gives all ones; REM/REMU gives op_a.
  - Signed overflow (op_a = most negative, op_b = -1): DIV gives op_a; REM gives 0.
- Output hold: out_result and out_tag stay stable while out_valid && !out_ready.
- Flush:
  - In any state, flush=1 forces the next state to IDLE and clears out_valid on the next edge. No result is produced.
  - flush together with in_valid in IDLE: no accept.
- in_ready = (state==IDLE). There is no overlap of ops; a new op can be accepted the cycle after the DONE handshake.
- Reset mid-operation: immediate return to IDLE. All partial state is discarded.

Optional Feature:
- RV_MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN multiplier. IDLE goes straight to DONE, so out_valid comes on cycle 1.
  - Divide is unchanged.
- Undefined: all multiplies take the iterative XLEN+1-cycle path. Results are bit-identical in both builds.

Decomposition:
- Shared package rv_pkg holds:
  - Enum muldiv_op_e for the fun3 encodings.
  - State enum muldiv_state_e {IDLE, CALC, DONE}.
  - OPCODE_OP (0110011) and FUN7_MULDIV (0000001) constants, reused by the decoder.
- One natural sub-module: rv_div_step, a combinational single restoring-division step (partial remainder, dividend bit → next remainder, quotient bit). It is instantiated once and stepped by the FSM.

Test Plan:
- MUL 7 × -3 (XLEN=32), tag 9 → out_result=0xFFFFFFEB, out_tag=9, out_valid on cycle 33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD (-3); REM -7 / 2 → 0xFFFFFFFF (-1); DIVU 100 / 7 → 14; REMU → 2.
- DIV 5 / 0 → 0xFFFFFFFF on cycle 1; REM 5 / 0 → 5; DIV 0x80000000 / -1 → 0x80000000; REM → 0.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE → result and tag stable, in_ready=0 throughout.
  - Assert flush at CALC step 10 → no out_valid; in_ready=1 on the next cycle; the next op computes correctly.
- Async reset:
  - Drop rst_n mid-CALC → outputs 0 and busy=0 immediately, without waiting for a clock edge.
  - With RV_MULDIV_FAST_MUL_EN defined, MUL 7 × -3 → same value, out_valid on cycle 1.
